piso_tx_ctrl: RTL and testbench
===============================

# piso_tx_ctrl

Upstream sequencer for the TMR shift register. Accepts parallel words over a valid/ready handshake and drives the register's `load`/`enable`/`mode`/`parallel_in` controls in PISO mode. It then samples the register's voted `serial_out` and re-emits each bit with a strobe, so the register becomes a paced serial transmitter. Optionally, its own control state is triplicated with majority voting, so the controller is as fault-tolerant as the datapath it drives.

## Interface
Parameters:
- `width`, 4: word width; must equal the driven register's `width`; ≥2.
- `BIT_CYCLES`, 1: clock cycles per transmitted bit; ≥1.

Ports:
- `clk`, in, 1: single clock; all state on rising edge.
- `rst`, in, 1: reset, synchronous, active-high.
- `in_valid`, in, 1: upstream word valid.
- `in_ready`, out, 1: controller can accept a word.
- `in_data`, in, `width`: word to transmit, bit 0 sent first.
- `reg_enable`, out, 1: to register `enable`.
- `reg_load`, out, 1: to register `load`.
- `reg_mode`, out, 2: to register `mode`; constant 2'b10 (PISO).
- `reg_parallel_in`, out, `width`: to register `parallel_in`.
- `reg_serial_out`, in, 1: voted `serial_out` from the register.
- `tx_data`, out, 1: transmitted bit, valid when `tx_valid`=1.
- `tx_valid`, out, 1: one-cycle bit strobe.
- `tx_last`, out, 1: high with the strobe of bit `width-1`.
- `busy`, out, 1: high in LOAD/SHIFT/DONE.
- `done`, out, 1: one-cycle pulse after the last bit.
- `ctrl_fault`, out, 1: controller TMR disagreement pulse (see Configuration).

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE. Internal registers: `hold[width]`, `bit_cnt` ($clog2(width) bits), `div_cnt` ($clog2(BIT_CYCLES) bits, minimum 1).
- IDLE:
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`: `hold`←`in_data`; go to LOAD.
- LOAD (1 cycle):
  - Drive `reg_enable`=1, `reg_load`=1, `reg_parallel_in`=`hold`.
  - Clear `bit_cnt` and `div_cnt`; go to SHIFT.
- SHIFT:
  - `div_cnt` increments each cycle.
  - When `div_cnt`==BIT_CYCLES-1, assert the strobe: `tx_valid`=1, `tx_data`=`reg_serial_out`, `reg_enable`=1, `reg_load`=0. The register shifts right; `div_cnt`←0; `bit_cnt`++.
  - On the strobe with `bit_cnt`==width-1: `tx_last`=1; go to DONE.
- DONE (1 cycle): `done`=1; go to IDLE.
- `reg_enable`=0 in every cycle not listed above; the register holds its contents.
- `reg_parallel_in`=`hold` in all states.
- `in_ready`=(state==IDLE)&&!`rst`. No word is accepted while busy; upstream must hold `in_valid`.
- Reset (any state, including mid-word):
  - State←IDLE; `hold`, `bit_cnt`, `div_cnt`←0.
  - All outputs 0 except `reg_mode`=2'b10 and `reg_parallel_in`=0.
  - An aborted word produces no `done`. The register's contents are not cleared by this block.
- `in_valid` asserted during reset is ignored.

## Timing
- Handshake in cycle T. LOAD in T+1; the register holds the word after the T+1 edge.
- Bit k strobe in cycle T+1+(k+1)·BIT_CYCLES, for k=0..width-1.
- `done` in T+2+width·BIT_CYCLES; `in_ready` again in the next cycle.
- Word period: width·BIT_CYCLES+3 cycles. With width=4 and BIT_CYCLES=1 this is 7.
- All outputs are decoded from registered state; there is no combinational path from `in_valid` to any output except `in_ready`'s reset term.

## Configuration
- Macro: `PISO_TX_CTRL_TMR_EN`.
- Defined:
  - State, `hold`, `bit_cnt` and `div_cnt` each have three copies.
  - Next-state logic uses the bitwise majority of the copies, and the voted next value is written to all three, so a single upset is scrubbed in one cycle.
  - `ctrl_fault`=1 in any cycle where any copy differs from the vote.
- Undefined: single copies; `ctrl_fault` tied to 0.
- Cycle timing is identical in both builds.

## Test plan
- width=4, BIT_CYCLES=1, `in_data`=4'b1011 accepted in cycle 0:
  - LOAD in cycle 1.
  - `tx_data` strobes 1,1,0,1 in cycles 2–5; `tx_last` in cycle 5.
  - `done` in cycle 6; `in_ready` in cycle 7.
- Back-to-back: 4'b0110 then 4'b1001 with `in_valid` held high:
  - Second word accepted in cycle 7.
  - Serial stream 0,1,1,0,1,0,0,1; `reg_enable` never asserted in IDLE/DONE.
- BIT_CYCLES=3, `in_data`=4'b0001:
  - Strobes in cycles 4, 7, 10, 13 with data 1,0,0,0.
  - `done` in cycle 14.
- Reset asserted in cycle 3 of a word, released in cycle 4:
  - No further `tx_valid` and no `done`.
  - `busy`=0 and `in_ready`=1 in cycle 5; the next word transmits correctly.
- `PISO_TX_CTRL_TMR_EN` defined, one `bit_cnt` copy forced wrong for one cycle mid-SHIFT:
  - `ctrl_fault` pulses once.
  - Serial stream and `done` timing unchanged.
- Same force without the macro: `ctrl_fault` stays 0.

Source files
------------

// File: rtl/piso_tx_ctrl.sv
// rtl/piso_tx_ctrl.sv - PISO transmit sequencer driving the TMR shift register
// Define PISO_TX_CTRL_TMR_EN to triplicate and majority-vote the controller state.
module piso_tx_ctrl #(
  parameter int width      = 4,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             reg_enable,
  output logic             reg_load,
  output logic [1:0]       reg_mode,
  output logic [width-1:0] reg_parallel_in,
  input  logic             reg_serial_out,
  output logic             tx_data,
  output logic             tx_valid,
  output logic             tx_last,
  output logic             busy,
  output logic             done,
  output logic             ctrl_fault
);
  localparam int BW = $clog2(width);
  localparam int DW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(width - 1);
  localparam logic [DW-1:0] LAST_DIV = DW'(BIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2, DONE = 2'd3} state_t;

  // *_v is the (voted) current state, *_n the next state computed from it
  state_t           state_v, state_n;
  logic [width-1:0] hold_v, hold_n;
  logic [BW-1:0]    bit_v, bit_n;
  logic [DW-1:0]    div_v, div_n;
  logic             strobe;

  assign strobe = (state_v == SHIFT) && (div_v == LAST_DIV);

  always_comb begin
    state_n = state_v;
    hold_n  = hold_v;
    bit_n   = bit_v;
    div_n   = div_v;
    case (state_v)
      IDLE: begin
        if (in_valid) begin
          hold_n  = in_data;
          state_n = LOAD;
        end
      end
      LOAD: begin
        bit_n   = '0;
        div_n   = '0;
        state_n = SHIFT;
      end
      SHIFT: begin
        if (strobe) begin
          div_n = '0;
          bit_n = bit_v + 1'b1;
          if (bit_v == LAST_BIT) state_n = DONE;
        end else begin
          div_n = div_v + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef PISO_TX_CTRL_TMR_EN
  state_t           state_a, state_b, state_c;
  logic [width-1:0] hold_a, hold_b, hold_c;
  logic [BW-1:0]    bit_cnt_a, bit_cnt_b, bit_cnt_c;
  logic [DW-1:0]    div_cnt_a, div_cnt_b, div_cnt_c;

  // All three copies take the voted next value, scrubbing a single upset in one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_a   <= IDLE;
      state_b   <= IDLE;
      state_c   <= IDLE;
      hold_a    <= '0;
      hold_b    <= '0;
      hold_c    <= '0;
      bit_cnt_a <= '0;
      bit_cnt_b <= '0;
      bit_cnt_c <= '0;
      div_cnt_a <= '0;
      div_cnt_b <= '0;
      div_cnt_c <= '0;
    end else begin
      state_a   <= state_n;
      state_b   <= state_n;
      state_c   <= state_n;
      hold_a    <= hold_n;
      hold_b    <= hold_n;
      hold_c    <= hold_n;
      bit_cnt_a <= bit_n;
      bit_cnt_b <= bit_n;
      bit_cnt_c <= bit_n;
      div_cnt_a <= div_n;
      div_cnt_b <= div_n;
      div_cnt_c <= div_n;
    end
  end

  assign state_v = state_t'((state_a & state_b) | (state_a & state_c) | (state_b & state_c));
  assign hold_v  = (hold_a & hold_b) | (hold_a & hold_c) | (hold_b & hold_c);
  assign bit_v   = (bit_cnt_a & bit_cnt_b) | (bit_cnt_a & bit_cnt_c) | (bit_cnt_b & bit_cnt_c);
  assign div_v   = (div_cnt_a & div_cnt_b) | (div_cnt_a & div_cnt_c) | (div_cnt_b & div_cnt_c);

  assign ctrl_fault = !rst && (
      (state_a != state_v) || (state_b != state_v) || (state_c != state_v) ||
      (hold_a != hold_v) || (hold_b != hold_v) || (hold_c != hold_v) ||
      (bit_cnt_a != bit_v) || (bit_cnt_b != bit_v) || (bit_cnt_c != bit_v) ||
      (div_cnt_a != div_v) || (div_cnt_b != div_v) || (div_cnt_c != div_v));
`else
  state_t           state_q;
  logic [width-1:0] hold_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [DW-1:0]    div_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
    end else begin
      state_q   <= state_n;
      hold_q    <= hold_n;
      bit_cnt_q <= bit_n;
      div_cnt_q <= div_n;
    end
  end

  assign state_v    = state_q;
  assign hold_v     = hold_q;
  assign bit_v      = bit_cnt_q;
  assign div_v      = div_cnt_q;
  assign ctrl_fault = 1'b0;
`endif

  // Outputs are decoded from registered state and forced quiet while rst is high
  assign in_ready        = (state_v == IDLE) && !rst;
  assign busy            = !rst && (state_v != IDLE);
  assign done            = !rst && (state_v == DONE);
  assign reg_load        = !rst && (state_v == LOAD);
  assign reg_enable      = !rst && ((state_v == LOAD) || strobe);
  assign reg_mode        = 2'b10;
  assign reg_parallel_in = rst ? '0 : hold_v;
  assign tx_valid        = !rst && strobe;
  assign tx_data         = tx_valid && reg_serial_out;
  assign tx_last         = tx_valid && (bit_v == LAST_BIT);

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// tb/tb_piso_tx_ctrl.sv - scoreboard bench for piso_tx_ctrl at BIT_CYCLES 1 and 3
module tb_piso_tx_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst[2];
  logic         in_valid[2];
  logic [W-1:0] in_data[2];
  logic         in_ready[2], reg_enable[2], reg_load[2];
  logic         tx_data[2], tx_valid[2], tx_last[2], busy[2], done[2], ctrl_fault[2];
  logic [1:0]   reg_mode[2];
  logic [W-1:0] reg_pin[2];

  // Instance 0 runs at one cycle per bit, instance 1 at three; each has a PISO register model
  for (genvar g = 0; g < 2; g++) begin : gi
    logic [W-1:0] q;
    always_ff @(posedge clk) begin
      if (reg_enable[g]) begin
        if (reg_load[g]) q <= reg_pin[g];
        else if (reg_mode[g] == 2'b10) q <= {1'b0, q[W-1:1]};
      end
    end
    piso_tx_ctrl #(.width(W), .BIT_CYCLES(g == 0 ? 1 : 3)) dut (
      .clk(clk), .rst(rst[g]), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_data(in_data[g]), .reg_enable(reg_enable[g]), .reg_load(reg_load[g]),
      .reg_mode(reg_mode[g]), .reg_parallel_in(reg_pin[g]), .reg_serial_out(q[0]),
      .tx_data(tx_data[g]), .tx_valid(tx_valid[g]), .tx_last(tx_last[g]),
      .busy(busy[g]), .done(done[g]), .ctrl_fault(ctrl_fault[g])
    );
  end

  typedef struct {int g; int c; logic d; logic l;} strobe_t;
  strobe_t      sq[$];
  logic         exp_busy[int], exp_done[int], exp_en[int], exp_fault[int];
  logic [W-1:0] exp_load[int];
  int n_pass = 0, n_tot = 0;

  function automatic int key(int c, int g);
    return c * 2 + g;
  endfunction

  task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", nm, g, cyc, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int c);
    while (cyc < c) tick;
  endtask

  task automatic expect_word(int g, int t, logic [W-1:0] d);
    int bc = (g == 0) ? 1 : 3;
    for (int c = t + 1; c <= t + 2 + W * bc; c++) exp_busy[key(c, g)] = 1'b1;
    exp_load[key(t + 1, g)] = d;
    exp_en[key(t + 1, g)]   = 1'b1;
    for (int k = 0; k < W; k++) begin
      int c = t + 1 + (k + 1) * bc;
      sq.push_back('{g, c, d[k], (k == W - 1)});
      exp_en[key(c, g)] = 1'b1;
    end
    exp_done[key(t + 2 + W * bc, g)] = 1'b1;
  endtask

  task automatic abort(int g, int r);
    strobe_t keep[$];
    for (int c = r; c < r + 64; c++) begin
      int k = key(c, g);
      if (exp_busy.exists(k)) exp_busy.delete(k);
      if (exp_done.exists(k)) exp_done.delete(k);
      if (exp_en.exists(k))   exp_en.delete(k);
      if (exp_load.exists(k)) exp_load.delete(k);
    end
    foreach (sq[i]) if (!(sq[i].g == g && sq[i].c >= r)) keep.push_back(sq[i]);
    sq = keep;
  endtask

  always @(negedge clk) begin
    int k;
    logic live;
    strobe_t s;
    for (int g = 0; g < 2; g++) begin
      k    = key(cyc, g);
      live = !rst[g];
      chk("busy",       g, busy[g],       live && exp_busy.exists(k));
      chk("in_ready",   g, in_ready[g],   live && !exp_busy.exists(k));
      chk("done",       g, done[g],       live && exp_done.exists(k));
      chk("reg_enable", g, reg_enable[g], live && exp_en.exists(k));
      chk("reg_load",   g, reg_load[g],   live && exp_load.exists(k));
      chk("reg_mode",   g, reg_mode[g],   2'b10);
      chk("ctrl_fault", g, ctrl_fault[g], live && exp_fault.exists(k));
      if (live && exp_load.exists(k)) chk("reg_parallel_in", g, reg_pin[g], exp_load[k]);
      if (!live) chk("reg_parallel_in_rst", g, reg_pin[g], 0);
      if (tx_valid[g]) begin
        if (sq.size() == 0 || sq[0].g != g) chk("tx_valid", g, tx_valid[g], 0);
        else begin
          s = sq.pop_front();
          chk("tx_cycle", g, cyc, s.c);
          chk("tx_data",  g, tx_data[g], s.d);
          chk("tx_last",  g, tx_last[g], s.l);
        end
      end else if (sq.size() > 0 && sq[0].g == g && sq[0].c <= cyc) begin
        chk("tx_valid", g, tx_valid[g], 1);
        void'(sq.pop_front());
      end
    end
  end

  initial begin
    int t, p;
    rst[0] = 1'b1; rst[1] = 1'b1;
    in_valid[0] = 1'b1; in_valid[1] = 1'b0;
    in_data[0] = 4'hF;  in_data[1] = 4'h0;
    repeat (3) tick;
    rst[0] = 1'b0; rst[1] = 1'b0;
    in_valid[0] = 1'b0;
    tick;

    for (int g = 0; g < 2; g++) begin
      p = W * ((g == 0) ? 1 : 3) + 3;

      // single word, bit 0 first
      t = cyc;
      in_valid[g] = 1'b1; in_data[g] = 4'b1011;
      expect_word(g, t, 4'b1011);
      tick;
      in_valid[g] = 1'b0;
`ifdef PISO_TX_CTRL_TMR_EN
      if (g == 0) begin
        wait_until(t + 3);
        force gi[0].dut.bit_cnt_b = 2'b11;
        exp_fault[key(t + 3, 0)] = 1'b1;
        #2;
        release gi[0].dut.bit_cnt_b;
      end
`endif
      wait_until(t + p);

      // back-to-back words with in_valid held high
      t = cyc;
      in_valid[g] = 1'b1; in_data[g] = 4'b0110;
      expect_word(g, t, 4'b0110);
      tick;
      in_data[g] = 4'b1001;
      expect_word(g, t + p, 4'b1001);
      wait_until(t + p);
      tick;
      in_valid[g] = 1'b0;
      wait_until(t + 2 * p);

      t = cyc;
      in_valid[g] = 1'b1; in_data[g] = 4'b0001;
      expect_word(g, t, 4'b0001);
      tick;
      in_valid[g] = 1'b0;
      wait_until(t + p);

      // reset mid-word, then a clean word
      t = cyc;
      in_valid[g] = 1'b1; in_data[g] = 4'b1101;
      expect_word(g, t, 4'b1101);
      tick;
      in_valid[g] = 1'b0;
      wait_until(t + 3);
      rst[g] = 1'b1;
      abort(g, t + 3);
      tick;
      rst[g] = 1'b0;
      tick;
      in_valid[g] = 1'b1; in_data[g] = 4'b0101;
      expect_word(g, t + 5, 4'b0101);
      tick;
      in_valid[g] = 1'b0;
      wait_until(t + 5 + p + 1);
    end

    repeat (4) tick;
    chk("pending_strobes", 0, sq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
